// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and default frame parameters.
// Used by uart_rx and uart_tx.
package uart_pkg;

  localparam int UART_NB_DATA = 8;
  localparam int UART_N_TICKS = 16;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous 1-bit input.
// RST_VAL sets the value both flops take on reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // first flop may go metastable; second gives a settled copy
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8N1 frames by default.
// Define UART_RX_PARITY_EN to add an even-parity bit before stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_DATA = UART_NB_DATA,
  parameter int N_TICKS = UART_N_TICKS
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic               o_rx_done,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_frame_err,
  output logic               o_parity_err
);

  localparam int TW = $clog2(N_TICKS);
  localparam int BW = $clog2(NB_DATA);

  localparam logic [TW-1:0] TICK_MID = TW'(N_TICKS / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(N_TICKS - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(NB_DATA - 1);

  logic               rx_s;
  uart_state_t        state;
  logic [TW-1:0]      tick_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [NB_DATA-1:0] shift;
  logic               stop_hit;
  logic               mid_hit;
  logic               end_hit;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  assign mid_hit  = i_tick && (tick_cnt == TICK_MID);
  assign end_hit  = i_tick && (tick_cnt == TICK_END);
  assign stop_hit = (state == ST_STOP) && end_hit;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_err;

  // even-parity check, sampled mid parity bit
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      par_bad <= 1'b0;
    end else if ((state == ST_PARITY) && end_hit) begin
      par_bad <= rx_s ^ (^shift);
    end
  end

  // parity flag registered alongside the byte
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      par_err <= 1'b0;
    end else if (stop_hit) begin
      par_err <= par_bad;
    end
  end

  assign o_parity_err = par_err;
`else
  assign o_parity_err = 1'b0;
`endif

  // frame FSM: start qualify, mid-bit sampling, bit counting
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (mid_hit) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? ST_IDLE : ST_DATA;
          end else if (i_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (end_hit) begin
            tick_cnt <= '0;
            shift    <= {rx_s, shift[NB_DATA-1:1]};
            if (bit_cnt == BIT_END) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (i_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (end_hit) begin
            tick_cnt <= '0;
            state    <= ST_STOP;
          end else if (i_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (end_hit) begin
            tick_cnt <= '0;
            state    <= ST_IDLE;
          end else if (i_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  // deliver byte and stop-bit status with a one-cycle strobe
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rx_done   <= 1'b0;
      o_data      <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_done <= stop_hit;
      if (stop_hit) begin
        o_data      <= shift;
        o_frame_err <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx.
// Define UART_RX_PARITY_EN to exercise the parity build.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int NB     = 8;
  localparam int NT     = 16;
  localparam int TDIV   = 4;
  localparam int BITCLK = NT * TDIV;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_tick = 1'b0;
  logic          i_rx = 1'b1;
  logic          o_rx_done;
  logic [NB-1:0] o_data;
  logic          o_frame_err;
  logic          o_parity_err;

  int errors = 0;
  int checks = 0;
  int tcnt = 0;

  // {data, frame_err, parity_err}
  logic [NB+1:0] got_q[$];
  logic [NB+1:0] exp_q[$];

  uart_rx #(
    .NB_DATA (NB),
    .N_TICKS (NT)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_tick       (i_tick),
    .i_rx         (i_rx),
    .o_rx_done    (o_rx_done),
    .o_data       (o_data),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    tcnt = (tcnt + 1) % TDIV;
    i_tick = (tcnt == 0);
  end

  always @(negedge i_clk) begin
    if (o_rx_done === 1'b1)
      got_q.push_back({o_data, o_frame_err, o_parity_err});
  end

  task automatic drive_bit(input logic v, input int n);
    i_rx = v;
    repeat (n) @(negedge i_clk);
  endtask

  // serial frame plus what the receiver must report for it
  task automatic send_frame(input logic [NB-1:0] d,
                            input logic stop,
                            input logic pflip);
    logic pe;
    pe = 1'b0;
    drive_bit(1'b0, BITCLK);
    for (int i = 0; i < NB; i++) drive_bit(d[i], BITCLK);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ pflip, BITCLK);
    pe = pflip;
`endif
    if (stop) begin
      drive_bit(1'b1, BITCLK);
    end else begin
      drive_bit(1'b0, BITCLK * 5 / 8);
      drive_bit(1'b1, BITCLK);
    end
    exp_q.push_back({d, ~stop, pe});
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_rx = 1'b1;
    repeat (5) @(negedge i_clk);
    #1;
    checks++;
    if ({o_rx_done, o_data, o_frame_err, o_parity_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {o_rx_done, o_data, o_frame_err, o_parity_err});
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (BITCLK) @(negedge i_clk);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, 1'b0);
    drive_bit(1'b1, 2 * BITCLK);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_frame[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (o_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_hold: got %h want a5", o_data);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_false_start();
    drive_bit(1'b0, 5 * TDIV);
    drive_bit(1'b1, 2 * BITCLK);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL false_start_pulse: got %0d want 0", got_q.size());
    end
    checks++;
    if (dut.state !== ST_IDLE) begin
      errors++;
      $display("FAIL false_start_state: got %0d want %0d", dut.state, ST_IDLE);
    end
    send_frame(8'h3C, 1'b1, 1'b0);
    drive_bit(1'b1, BITCLK);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL false_start_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL false_start_frame[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_frame_err();
    send_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0);
    drive_bit(1'b1, BITCLK);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL frame_err_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL frame_err_frame[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drive_bit(1'b1, BITCLK);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_frame[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] d;
    d = 8'h55;
    drive_bit(1'b0, BITCLK);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BITCLK);
    drive_bit(d[4], BITCLK / 2);
    i_reset = 1'b1;
    #1;
    checks++;
    if ({o_rx_done, o_data, o_frame_err, o_parity_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h want 0",
               {o_rx_done, o_data, o_frame_err, o_parity_err});
    end
    i_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    drive_bit(1'b1, 12 * BITCLK);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_pulse: got %0d want 0", got_q.size());
    end
    got_q.delete();
    send_frame(d, 1'b1, 1'b0);
    drive_bit(1'b1, BITCLK);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid_frame[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      send_frame(NB'($urandom),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
      drive_bit(1'b1, $urandom_range(0, BITCLK));
    end
    drive_bit(1'b1, BITCLK);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_frame[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1, BITCLK);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL parity_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL parity_frame[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
